// File: rtl/instr_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq
// Brief    : Multi-cycle instruction sequencer. Walks IDLE/FETCH/DECODE/EXEC/
//            MEM/WB per instruction, emits datapath strobes and counts
//            retired instructions. HALT is sticky until reset.
// Revision : 1.0 - initial release
// ============================================================================
module instr_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        cu_en,
  output logic        reg_we,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_TR, CL_LOAD, CL_STORE, CL_PSH, CL_POP,
    CL_BR, CL_ALU, CL_MOV, CL_HLT, CL_ILL
  } opclass_t;

  // Map a raw opcode onto its instruction class.
  function automatic opclass_t classify(input logic [5:0] op);
    case (op)
      6'd0, 6'd1:                      classify = CL_TR;
      6'd2:                            classify = CL_LOAD;
      6'd3:                            classify = CL_STORE;
      6'd4:                            classify = CL_PSH;
      6'd5:                            classify = CL_POP;
      6'd6, 6'd7, 6'd8, 6'd9, 6'd10:   classify = CL_BR;
      6'd20, 6'd21, 6'd22:             classify = CL_ALU;
      6'd23:                           classify = CL_MOV;
      6'd63:                           classify = CL_HLT;
      default:                         classify = CL_ILL;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_opcode;
  logic        r_err;
  logic [15:0] r_instret;
  logic        w_retire;
  logic        w_set_err;
  opclass_t    w_cls_live;
  opclass_t    w_cls_held;

  // The live opcode is only trusted in DECODE; later states use the held copy.
  assign w_cls_live = classify(opcode);
  assign w_cls_held = classify(r_opcode);

  assign state   = r_state;
  assign halted  = (r_state == S_HALT);
  assign err     = r_err;
  assign instret = r_instret;

  // Next-state, strobe and retirement decode for the current state.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    cu_en        = 1'b0;
    reg_we       = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    w_retire     = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load      = 1'b1;
          pc_inc       = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_cls_live == CL_HLT) begin
          w_next_state = S_HALT;
        end else if (w_cls_live == CL_ILL) begin
          w_next_state = S_HALT;
          w_set_err    = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        cu_en = 1'b1;
        case (w_cls_held)
          CL_LOAD, CL_STORE, CL_PSH, CL_POP: w_next_state = S_MEM;
          CL_BR: begin
            pc_load      = branch_taken;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_cls_held == CL_STORE) || (w_cls_held == CL_PSH);
        if (mem_ready) begin
          case (w_cls_held)
            CL_PSH: begin
              sp_dec       = 1'b1;
              w_retire     = 1'b1;
              w_next_state = S_FETCH;
            end
            CL_POP: begin
              sp_inc       = 1'b1;
              w_next_state = S_WB;
            end
            CL_STORE: begin
              w_retire     = 1'b1;
              w_next_state = S_FETCH;
            end
            default: w_next_state = S_WB;
          endcase
        end
      end
      S_WB: begin
        reg_we       = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Capture the opcode while decoding so later opcode changes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_opcode <= 6'd0;
    else if (r_state == S_DECODE) r_opcode <= opcode;
  end

  // Sticky error flag raised by an illegal opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_set_err) r_err <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= 16'd0;
    else if (w_retire) r_instret <= r_instret + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_seq
// Brief    : Self-checking bench for instr_seq: opcode table, directed
//            multi-cycle sequences and a randomized run against a
//            route-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_seq;

  logic        clk = 1'b0;
  logic        rst, start, branch_taken, mem_ready;
  logic [5:0]  opcode;
  logic        mem_req, mem_we, ir_load, pc_inc, pc_load, cu_en, reg_we;
  logic        sp_inc, sp_dec, halted, err;
  logic [2:0]  state;
  logic [15:0] instret;

  instr_seq dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .cu_en(cu_en), .reg_we(reg_we), .sp_inc(sp_inc),
    .sp_dec(sp_dec), .halted(halted), .err(err), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {2'b00, state, mem_req, mem_we, ir_load, pc_inc, pc_load, cu_en,
            reg_we, sp_inc, sp_dec, halted, err, instret};
  endfunction

  // ---------------- reference model: instruction = route of phases --------
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                 P_MEM = 4, P_WB = 5, P_HALT = 6;
  localparam int K_TR = 0, K_LOAD = 1, K_STORE = 2, K_PSH = 3, K_POP = 4,
                 K_BR = 5, K_ALU = 6, K_MOV = 7, K_HLT = 8, K_ILL = 9;

  int          m_ph, m_cls;
  int          route[$];
  logic [15:0] m_ir;
  logic        m_err, m_done;

  function automatic int kind(input logic [5:0] op);
    int v = int'(op);
    if (v <= 1)              return K_TR;
    if (v == 2)              return K_LOAD;
    if (v == 3)              return K_STORE;
    if (v == 4)              return K_PSH;
    if (v == 5)              return K_POP;
    if (v >= 6 && v <= 10)   return K_BR;
    if (v >= 20 && v <= 22)  return K_ALU;
    if (v == 23)             return K_MOV;
    if (v == 63)             return K_HLT;
    return K_ILL;
  endfunction

  task automatic plan(input int k);
    route.delete();
    case (k)
      K_TR, K_ALU, K_MOV: begin route.push_back(P_EXEC); route.push_back(P_WB); end
      K_LOAD, K_POP: begin
        route.push_back(P_EXEC); route.push_back(P_MEM); route.push_back(P_WB);
      end
      K_STORE, K_PSH: begin route.push_back(P_EXEC); route.push_back(P_MEM); end
      K_BR:    route.push_back(P_EXEC);
      default: route.push_back(P_HALT);
    endcase
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_cls = K_TR; route.delete(); m_ir = 16'd0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_eval(output logic [31:0] e);
    logic mr = 0, mw = 0, il = 0, pi = 0, pl = 0, ce = 0, rw = 0, si = 0, sd = 0;
    if (rst) model_reset();
    m_done = 1'b0;
    if (!rst) begin
      case (m_ph)
        P_IDLE:   m_done = start;
        P_FETCH:  begin mr = 1; if (mem_ready) begin il = 1; pi = 1; m_done = 1; end end
        P_DECODE: m_done = 1;
        P_EXEC:   begin ce = 1; pl = (m_cls == K_BR) && branch_taken; m_done = 1; end
        P_MEM: begin
          mr = 1;
          mw = (m_cls == K_STORE) || (m_cls == K_PSH);
          if (mem_ready) begin
            m_done = 1;
            sd = (m_cls == K_PSH);
            si = (m_cls == K_POP);
          end
        end
        P_WB:     begin rw = 1; m_done = 1; end
        default:  m_done = 0;
      endcase
    end
    e = {2'b00, 3'(m_ph), mr, mw, il, pi, pl, ce, rw, si, sd,
         (m_ph == P_HALT), m_err, m_ir};
  endtask

  task automatic model_commit();
    if (rst || !m_done) return;
    case (m_ph)
      P_IDLE:  m_ph = P_FETCH;
      P_FETCH: m_ph = P_DECODE;
      P_DECODE: begin
        m_cls = kind(opcode);
        plan(m_cls);
        if (m_cls == K_ILL) m_err = 1'b1;
        m_ph = route.pop_front();
      end
      default: begin
        if (route.size() == 0) begin m_ir = m_ir + 16'd1; m_ph = P_FETCH; end
        else m_ph = route.pop_front();
      end
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; mem_ready = 0; branch_taken = 0; #2;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic [5:0] op; logic bt; int lat; int fin;
    int pcl; int spi; int spd; int wec; int ret; logic er;
  } row_t;

  row_t tbl[17];
  logic [5:0] legal_ops [15] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                 6'd8, 6'd9, 6'd10, 6'd20, 6'd21, 6'd22, 6'd23};
  logic [5:0] bad_ops [7] = '{6'd11, 6'd12, 6'd15, 6'd19, 6'd24, 6'd40, 6'd62};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int lat, pcl, spi, spd, wec, cnt, halt_cnt, r, ir0;
    logic [2:0]  exp_st [6];
    logic [31:0] e;

    //           op    bt  lat fin pcl spi spd wec ret er
    tbl[0]  = '{6'd0,  0, 4, 1, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{6'd1,  0, 4, 1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{6'd2,  0, 5, 1, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{6'd3,  0, 4, 1, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{6'd4,  0, 4, 1, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{6'd5,  0, 5, 1, 0, 1, 0, 0, 1, 0};
    tbl[6]  = '{6'd6,  1, 3, 1, 1, 0, 0, 0, 1, 0};
    tbl[7]  = '{6'd10, 0, 3, 1, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{6'd8,  1, 3, 1, 1, 0, 0, 0, 1, 0};
    tbl[9]  = '{6'd20, 1, 4, 1, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{6'd22, 0, 4, 1, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{6'd23, 0, 4, 1, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{6'd63, 0, 2, 6, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{6'd15, 0, 2, 6, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{6'd11, 0, 2, 6, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{6'd19, 0, 2, 6, 0, 0, 0, 0, 0, 1};
    tbl[16] = '{6'd24, 1, 2, 6, 0, 0, 0, 0, 0, 1};

    // Reset state
    rst = 1; start = 0; opcode = 0; branch_taken = 0; mem_ready = 0;
    #2;
    chk("reset_outputs", obs(), 32'd0);
    tick(); rst = 0;

    // Opcode table: latency from FETCH entry, strobes and retirement
    foreach (tbl[i]) begin
      do_reset();
      opcode = tbl[i].op; branch_taken = tbl[i].bt; mem_ready = 1; start = 1;
      tick(); start = 0;
      lat = 0; pcl = 0; spi = 0; spd = 0; wec = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        pcl += int'(pc_load); spi += int'(sp_inc); spd += int'(sp_dec); wec += int'(mem_we);
        tick(); lat++;
        if (state == 3'd1 || state == 3'd6) break;
      end
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_state", i), {29'd0, state}, tbl[i].fin);
      chk($sformatf("tbl%0d_pc_load", i), pcl, tbl[i].pcl);
      chk($sformatf("tbl%0d_sp_inc", i), spi, tbl[i].spi);
      chk($sformatf("tbl%0d_sp_dec", i), spd, tbl[i].spd);
      chk($sformatf("tbl%0d_mem_we", i), wec, tbl[i].wec);
      chk($sformatf("tbl%0d_instret", i), {16'd0, instret}, tbl[i].ret);
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].er});
    end

    // TR walk-through; start must be seen before leaving IDLE
    do_reset();
    opcode = 0; mem_ready = 1;
    repeat (2) begin @(negedge clk); chk("idle_wait_start", {29'd0, state}, 0); tick(); end
    start = 1;
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("tr_state%0d", k), {29'd0, state}, {29'd0, exp_st[k]});
      if (k == 3) chk("tr_cu_en", {31'd0, cu_en}, 1);
      if (k == 4) chk("tr_reg_we", {31'd0, reg_we}, 1);
      tick(); start = 0;
    end
    chk("tr_instret", {16'd0, instret}, 1);

    // PSH with mem_ready delayed three cycles in MEM
    do_reset();
    opcode = 4; mem_ready = 1; start = 1;
    tick(); start = 0; tick(); tick(); tick();   // now in MEM
    cnt = 0; spd = 0;
    for (int k = 0; k < 10; k++) begin
      mem_ready = (k >= 3);
      @(negedge clk);
      if (state != 3'd4) break;
      if (mem_req && mem_we) cnt++;
      spd += int'(sp_dec);
      tick();
    end
    chk("psh_mem_cycles", cnt, 4);
    chk("psh_sp_dec", spd, 1);
    chk("psh_no_wb", {29'd0, state}, 1);
    chk("psh_instret", {16'd0, instret}, 1);
    tick();

    // Taken then not-taken branch
    do_reset();
    opcode = 6; mem_ready = 1; start = 1;
    tick(); start = 0;
    for (int k = 0; k < 6; k++) begin
      branch_taken = (k < 3);
      @(negedge clk);
      if (k == 2) chk("br_taken_pc_load", {31'd0, pc_load}, 1);
      if (k == 5) chk("br_not_taken_pc_load", {31'd0, pc_load}, 0);
      tick();
    end
    chk("br_state", {29'd0, state}, 1);
    chk("br_instret", {16'd0, instret}, 2);

    // Illegal opcode: sticky HALT, start ignored
    do_reset();
    opcode = 15; mem_ready = 1; start = 1;
    tick(); start = 0; tick(); tick();
    for (int k = 0; k < 4; k++) begin
      start = k[0]; opcode = 0;
      @(negedge clk);
      chk($sformatf("halt_hold%0d", k), obs(), {2'b00, 3'd6, 9'd0, 1'b1, 1'b1, 16'd0});
      tick();
    end

    // Reset in the middle of a POP memory wait
    do_reset();
    opcode = 0; mem_ready = 1; start = 1;
    tick(); start = 0; tick(); tick(); tick(); tick();  // TR retired, back in FETCH
    opcode = 5; tick(); mem_ready = 0; tick(); tick();  // now in MEM
    @(negedge clk);
    chk("pop_in_mem", {29'd0, state}, 4);
    chk("pop_instret_before", {16'd0, instret}, 1);
    #2 rst = 1;
    #1;
    chk("pop_rst_async", obs(), 32'd0);
    mem_ready = 1; spi = 0;
    tick(); rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      spi += int'(sp_inc) + int'(reg_we) + int'(state != 3'd0);
      tick();
    end
    chk("pop_after_rst_quiet", spi, 0);

    // Counter wrap from 0xFFFF
    do_reset();
    @(negedge clk);
    force dut.r_instret = 16'hFFFF;
    #1 release dut.r_instret;
    #1 chk("wrap_preload", {16'd0, instret}, 32'h0000FFFF);
    tick();
    opcode = 0; mem_ready = 1; start = 1;
    tick(); start = 0; tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("wrap_instret", {16'd0, instret}, 0);
    tick();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    halt_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      start        = ($urandom_range(0, 3) == 0);
      mem_ready    = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      if (r == 0)      opcode = 6'd63;
      else if (r < 3)  opcode = bad_ops[$urandom_range(0, 6)];
      else             opcode = legal_ops[$urandom_range(0, 14)];
      rst = (m_ph == P_HALT && halt_cnt > 3) || ($urandom_range(0, 299) == 0);
      @(negedge clk);
      model_eval(e);
      ir0 = int'(m_ir);
      chk("rand", obs(), e);
      @(posedge clk);
      model_commit();
      #1;
      halt_cnt = (m_ph == P_HALT) ? halt_cnt + 1 : 0;
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 The block SHALL have a clock input: clk, input, 1 bit, rising-edge system clock.
REQ-002 The block SHALL have a reset input: rst, input, 1 bit, asynchronous, active-high.
REQ-003 The block SHALL have an input start: 1 bit, single-cycle request to leave IDLE.
REQ-004 The block SHALL have an input opcode: 6 bits, instruction-register opcode field, valid from DECODE onward.
REQ-005 The block SHALL have an input branch_taken: 1 bit, condition-met result from flag logic, sampled in EXEC.
REQ-006 The block SHALL have an input mem_ready: 1 bit, memory transfer-complete strobe.
REQ-007 The block SHALL have outputs mem_req and mem_we: 1 bit each, memory request and write qualifier.
REQ-008 The block SHALL have outputs ir_load, pc_inc, pc_load, cu_en, reg_we, sp_inc and sp_dec: 1-bit single-cycle strobes.
REQ-009 The block SHALL have outputs halted and err: 1 bit each, status flags.
REQ-010 The block SHALL have an output state: 3 bits, current FSM state encoding.
REQ-011 The block SHALL have an output instret: 16 bits, retired-instruction counter.

Function
REQ-012 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 is unreachable and SHALL recover to IDLE on the next clock.
REQ-013 Opcode classes SHALL be:
- TR = 0-1
- LOAD = 2
- STORE = 3
- PSH = 4
- POP = 5
- BR = 6-10
- ALU = 20-22
- MOV = 23
- HLT = 63
- every other value is illegal.
REQ-014 IDLE transitions:
- start=1 -> FETCH next cycle
- start=0 -> remain in IDLE
- all strobes low in IDLE.
REQ-015 FETCH behaviour:
- mem_req=1 and mem_we=0 every cycle in FETCH
- on mem_ready=1: ir_load=1 and pc_inc=1 in that same cycle, -> DECODE
- otherwise remain in FETCH (unbounded wait).
REQ-016 DECODE SHALL last one cycle with no strobes asserted; transitions:
- HLT -> HALT
- illegal opcode -> HALT with err set to 1
- otherwise -> EXEC.
REQ-017 EXEC SHALL last one cycle with cu_en=1; transitions:
- TR, ALU, MOV -> WB
- LOAD, STORE, PSH, POP -> MEM
- BR -> FETCH, with pc_load=1 in EXEC only if branch_taken=1.
REQ-018 MEM behaviour:
- mem_req=1 every cycle in MEM
- mem_we=1 for STORE and PSH, mem_we=0 for LOAD and POP.
REQ-019 MEM completion on mem_ready=1:
- PSH: sp_dec=1, -> FETCH
- POP: sp_inc=1, -> WB
- LOAD: -> WB
- STORE: -> FETCH.
REQ-020 WB SHALL last one cycle with reg_we=1, -> FETCH.
REQ-021 The opcode SHALL be latched internally in DECODE; opcode changes after DECODE SHALL NOT affect the EXEC, MEM or WB decisions.
REQ-022 instret SHALL increment by 1 on the cycle an instruction retires:
- retirement points are the WB exit, the STORE/PSH MEM exit, and the BR EXEC exit
- HLT and illegal opcodes SHALL NOT count
- instret wraps from 0xFFFF to 0x0000.
REQ-023 mem_ready SHALL be ignored in every state except FETCH and MEM.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 HALT SHALL hold halted=1 with all strobes low and SHALL be left only by reset.
REQ-026 At most one of pc_inc and pc_load SHALL be high in any cycle.
REQ-027 At most one of sp_inc and sp_dec SHALL be high in any cycle.
REQ-028 Memory-wait-free latencies measured from FETCH entry SHALL be:
- TR/ALU/MOV: 4 cycles
- LOAD/POP: 5 cycles
- STORE/PSH: 4 cycles
- BR: 3 cycles.

Reset
REQ-029 On rst=1, asynchronously and without waiting for clk:
- state -> IDLE
- all strobes and mem_req/mem_we -> 0
- halted=0, err=0, instret=0
- latched opcode -> 0.
REQ-030 Reset asserted during FETCH or MEM SHALL drop mem_req immediately, abandoning the transfer; no sp_inc, sp_dec or reg_we pulse is produced for that instruction.
REQ-031 After rst deasserts, the first state change SHALL require start=1 sampled on a rising clk.

Verification
REQ-032 Scenario: start, mem_ready tied 1, opcode=0 -> states IDLE,FETCH,DECODE,EXEC,WB,FETCH; reg_we high in the cycle after cu_en; instret=1.
REQ-033 Scenario: opcode=4 (PSH), mem_ready delayed 3 cycles in MEM -> mem_req=1 and mem_we=1 for 4 MEM cycles; sp_dec single pulse; no WB; instret increments by 1.
REQ-034 Scenario: opcode=6, branch_taken=1 then a second instance with branch_taken=0 -> pc_load pulse in EXEC only for the first; both return to FETCH; instret=2.
REQ-035 Scenario: opcode=15 (illegal) -> HALT after DECODE; err=1; halted=1; start pulses ignored; instret unchanged.
REQ-036 Scenario: rst pulse mid-MEM of a POP -> mem_req low immediately; no sp_inc; state=0, instret=0.
REQ-037 Scenario: preload 0xFFFF retirements (or force the counter to 0xFFFF), then retire one TR -> instret=0x0000.
